// File: rtl/weight_decompressor_if.sv
// Handshake bundle between the compressed
// stream source, the decompressor and the driver.
interface weight_decompressor_if #(
  parameter int MEM_BW = 128,
  parameter int CNT_W  = 16
);
  logic              comp_valid_in;
  logic              comp_ready_out;
  logic [MEM_BW-1:0] comp_data_in;
  logic              word_valid_out;
  logic              word_ready_in;
  logic [MEM_BW-1:0] word_data_out;
  logic [CNT_W-1:0]  block_count_out;

  modport slave (
    input  comp_valid_in,
    input  comp_data_in,
    input  word_ready_in,
    output comp_ready_out,
    output word_valid_out,
    output word_data_out,
    output block_count_out
  );

  modport master (
    output comp_valid_in,
    output comp_data_in,
    output word_ready_in,
    input  comp_ready_out,
    input  word_valid_out,
    input  word_data_out,
    input  block_count_out
  );
endinterface

// File: rtl/weight_decompressor.sv
// Zero-value weight decompressor: mask-coded
// byte stream in, one dense weight word per block out.
module weight_decompressor #(
  parameter int IO_DATA_WIDTH = 8,
  parameter int MEM_BW        = 128,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 arst_n_in,
  input  logic                 clear_in,
  weight_decompressor_if.slave bus
);
  localparam int BW    = IO_DATA_WIDTH;
  localparam int N     = MEM_BW / BW;
  localparam int MB    = N / 8;
  localparam int DEPTH = 2 * N;
  localparam int FW    = $clog2(DEPTH + 1);
  localparam int IW    = $clog2(DEPTH);
  localparam int NW    = $clog2(N);

  logic [BW-1:0]     bytes_q [DEPTH];
  logic [FW-1:0]     fill_q;
  logic              valid_q;
  logic [MEM_BW-1:0] word_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [BW-1:0]     in_b    [N];
  logic [BW-1:0]     view    [DEPTH];
  logic [BW-1:0]     bytes_d [DEPTH];
  logic [FW-1:0]     view_fill;
  logic [FW-1:0]     fill_d;
  logic [FW-1:0]     need;
  logic [FW-1:0]     used;
  logic [N-1:0]      mask;
  logic [MEM_BW-1:0] dense;
  logic              accept;
  logic              drain;
  logic              load;

  assign bus.comp_ready_out =
    (fill_q <= FW'(N)) && !clear_in;

  assign accept = bus.comp_valid_in &&
                  bus.comp_ready_out;
  assign drain  = valid_q && bus.word_ready_in;

  // Split the incoming word into stream-ordered bytes
  always_comb begin
    for (int k = 0; k < N; k++)
      in_b[k] = bus.comp_data_in[MEM_BW-1-BW*k -: BW];
  end

  // Buffered bytes followed by the word being
  // accepted now, so a block can finish this cycle
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      view[j] = '0;
      if (FW'(j) < fill_q)
        view[j] = bytes_q[j];
      else if (accept &&
               (FW'(j) < fill_q + FW'(N)))
        view[j] =
          in_b[NW'(IW'(j) - IW'(fill_q))];
    end
  end

  assign view_fill =
    fill_q + (accept ? FW'(N) : FW'(0));

  // Head mask, block length and dense expansion
  always_comb begin
    logic [IW-1:0] idx;
    mask  = '0;
    need  = FW'(MB);
    dense = '0;
    idx   = IW'(MB);
    for (int i = 0; i < N; i++) begin
      mask[i] = view[i / BW][BW - 1 - (i % BW)];
      need    = need + FW'(mask[i]);
    end
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        dense[MEM_BW-1-BW*i -: BW] = view[idx];
        idx = idx + IW'(1);
      end
    end
  end

  assign load = !clear_in &&
                (view_fill >= FW'(MB)) &&
                (view_fill >= need) &&
                (!valid_q || bus.word_ready_in);

  assign used   = load ? need : FW'(0);
  assign fill_d = view_fill - used;

  // Drop the consumed block from the head
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      bytes_d[j] = '0;
      if (j + int'(used) < DEPTH)
        bytes_d[j] = view[IW'(j + int'(used))];
    end
  end

  // Byte buffer and fill level
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      fill_q <= '0;
      for (int j = 0; j < DEPTH; j++)
        bytes_q[j] <= '0;
    end else if (clear_in) begin
      fill_q <= '0;
      for (int j = 0; j < DEPTH; j++)
        bytes_q[j] <= '0;
    end else begin
      fill_q  <= fill_d;
      bytes_q <= bytes_d;
    end
  end

  // Single output slot; holds while stalled
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else if (clear_in) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      word_q  <= dense;
    end else if (drain) begin
      valid_q <= 1'b0;
    end
  end

  // Emitted-block counter, wraps naturally
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in)
      cnt_q <= '0;
    else if (clear_in)
      cnt_q <= '0;
    else if (drain)
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.word_valid_out  = valid_q;
  assign bus.word_data_out   = word_q;
  assign bus.block_count_out = cnt_q;
endmodule
